// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader: big-endian byte stream -> 32-bit word writes, CPU held until done.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module instr_mem_loader #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
`ifdef LOADER_CHECKSUM_EN
        S_CKSUM,
`endif
        S_ERR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_FINISH = S_CKSUM;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state, state_next;
    logic [7:0]  len_hi;
    logic [15:0] word_count;
    logic [15:0] len_word;
    logic [23:0] asm_word;
    logic [1:0]  byte_cnt;
    logic        accept;
    logic        start_load;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  cksum;
`endif

    assign accept     = in_valid && in_ready;
    assign len_word   = {len_hi, in_data};
    assign start_load = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_word == 16'd0)              state_next = S_FINISH;
                    else if ({1'b0, len_word} > MAX_W) state_next = S_ERR;
                    else                                state_next = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && byte_cnt == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                imem_we = 1'b1;
                if (words_loaded + 16'd1 == word_count) state_next = S_FINISH;
                else                                    state_next = S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CKSUM: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (in_data == cksum) ? S_DONE : S_ERR;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Control and visible outputs; status flags track the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt     <= 2'd0;
            words_loaded <= 16'd0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            done     <= (state_next == S_DONE);
            error    <= (state_next == S_ERR);
            cpu_hold <= (state_next != S_DONE);
            if (start_load) begin
                byte_cnt     <= 2'd0;
                words_loaded <= 16'd0;
            end
            if (state == S_DATA && accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    imem_wdata <= {asm_word, in_data};
                    imem_addr  <= BASE_ADDR + (ADDR_WIDTH'(words_loaded) << 2);
                end
            end
            if (state == S_WRITE) words_loaded <= words_loaded + 16'd1;
        end
    end

    // Pure datapath: every field is rewritten before it is consumed in a load.
    always_ff @(posedge clk) begin
        if (state == S_LEN_HI && accept) len_hi <= in_data;
        if (state == S_LEN_LO && accept) word_count <= len_word;
        if (state == S_DATA && accept)   asm_word <= {asm_word[15:0], in_data};
`ifdef LOADER_CHECKSUM_EN
        if (start_load) cksum <= 8'd0;
        else if (accept && state != S_CKSUM) cksum <= cksum ^ in_data;
`endif
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (default and LOADER_CHECKSUM_EN builds).
`timescale 1ns/1ps
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    instr_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

`ifdef LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       err;
        logic       dn;
        logic       hold;
        logic       rdy;
    } hdr_t;

    int          tests = 0;
    int          fails = 0;
    int          acc_cnt = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [7:0]  xr = 8'd0;

    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
        if (rst_n && in_valid && in_ready) acc_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        xr = 8'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        bit got;
        k = 0;
        got = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!got && k < 50) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            k++;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL send_byte %0h: in_ready stayed 0, required 1", b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            xr = xr ^ b;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = xr;
        send_byte(c);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        hdr_t hdrs[4];
        int   n0;
        int   a0;
        hdrs[0] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        hdrs[1] = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        hdrs[2] = '{8'h01, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
        hdrs[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};

        // reset values
        repeat (2) @(posedge clk);
        #2;
        chk("rst cpu_hold", cpu_hold, 1);
        chk("rst done", done, 0);
        chk("rst error", error, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst imem_we", imem_we, 0);
        chk("rst words_loaded", words_loaded, 0);
        #1 rst_n = 1'b1;

        // bytes without start are ignored
        a0 = acc_cnt;
        n0 = wa.size();
        in_data  = 8'h55;
        in_valid = 1'b1;
        tick(10);
        chk("nostart in_ready", in_ready, 0);
        chk("nostart accepts", acc_cnt - a0, 0);
        chk("nostart writes", wa.size() - n0, 0);
        in_valid = 1'b0;

        // two-word program
        pulse_start();
        #1;
        chk("start in_ready", in_ready, 1);
        chk("start cpu_hold", cpu_hold, 1);
        n0 = wa.size();
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h20080005);
        send_word(32'h8C090004);
`ifndef LOADER_CHECKSUM_EN
        #1;
        chk("last write imem_we", imem_we, 1);
        chk("last write in_ready", in_ready, 0);
        chk("last write cpu_hold", cpu_hold, 1);
        tick(1);
        chk("done entry done", done, 1);
        chk("done entry cpu_hold", cpu_hold, 0);
`else
        chk("cksum value", xr, 8'hAE);
        finish_load();
        tick(1);
`endif
        chk("main write count", wa.size() - n0, 2);
        chk("main addr0", wa[n0], 32'h0);
        chk("main data0", wd[n0], 32'h20080005);
        chk("main addr1", wa[n0+1], 32'h4);
        chk("main data1", wd[n0+1], 32'h8C090004);
        chk("main words_loaded", words_loaded, 2);
        chk("main done", done, 1);
        chk("main cpu_hold", cpu_hold, 0);
        chk("main error", error, 0);

        // header boundary table
        for (int i = 0; i < 4; i++) begin
            do_reset();
            pulse_start();
            send_byte(hdrs[i].hi);
            send_byte(hdrs[i].lo);
            if (CK == 1 && {hdrs[i].hi, hdrs[i].lo} == 16'd0) finish_load();
            tick(2);
            chk($sformatf("hdr%0d error", i), error, hdrs[i].err);
            chk($sformatf("hdr%0d done", i), done, hdrs[i].dn);
            chk($sformatf("hdr%0d cpu_hold", i), cpu_hold, hdrs[i].hold);
            chk($sformatf("hdr%0d in_ready", i), in_ready, hdrs[i].rdy);
            chk($sformatf("hdr%0d words_loaded", i), words_loaded, 0);
        end

        // recovery from ERR
        pulse_start();
        #1;
        chk("recover error cleared", error, 0);
        n0 = wa.size();
        send_byte(8'h00); send_byte(8'h01);
        send_word(32'h12345678);
        finish_load();
        tick(2);
        chk("recover done", done, 1);
        chk("recover data", wd[n0], 32'h12345678);
        chk("recover addr", wa[n0], 32'h0);

        // gapped valid across one word; byte offered during WRITE not taken
        do_reset();
        pulse_start();
        a0 = acc_cnt;
        n0 = wa.size();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); tick(1);
        send_byte(8'hAD); tick(1);
        send_byte(8'hBE); tick(1);
        send_byte(8'hEF);
        in_data  = 8'h77;
        in_valid = 1'b1;
        #1;
        chk("gap write in_ready", in_ready, 0);
        chk("gap write imem_we", imem_we, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        finish_load();
        tick(2);
        chk("gap accepts", acc_cnt - a0, 6 + CK);
        chk("gap write count", wa.size() - n0, 1);
        chk("gap data", wd[n0], 32'hDEADBEEF);
        chk("gap addr", wa[n0], 32'h0);
        chk("gap done", done, 1);

        // asynchronous reset in the middle of the second word
        do_reset();
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'hA1B2C3D4);
        send_byte(8'hAA); send_byte(8'hBB);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst in_ready", in_ready, 0);
        chk("midrst cpu_hold", cpu_hold, 1);
        chk("midrst imem_we", imem_we, 0);
        chk("midrst words_loaded", words_loaded, 0);
        chk("midrst imem_wdata", imem_wdata, 0);
        chk("midrst imem_addr", imem_addr, 0);
        chk("midrst done", done, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        pulse_start();
        n0 = wa.size();
        send_byte(8'h00); send_byte(8'h01);
        send_word(32'hCAFEF00D);
        finish_load();
        tick(2);
        chk("reload addr", wa[n0], 32'h0);
        chk("reload data", wd[n0], 32'hCAFEF00D);
        chk("reload words_loaded", words_loaded, 1);
        chk("reload done", done, 1);

`ifdef LOADER_CHECKSUM_EN
        // wrong trailing checksum
        do_reset();
        pulse_start();
        n0 = wa.size();
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h20080005);
        send_word(32'h8C090004);
        send_byte(8'hFF);
        tick(2);
        chk("badck write count", wa.size() - n0, 2);
        chk("badck error", error, 1);
        chk("badck done", done, 0);
        chk("badck cpu_hold", cpu_hold, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
